vram_arbiter: RTL and testbench

Time-slot arbiter sharing one single-port synchronous video RAM between the pixel scan-out path and the ioctl download path. Scan-out reads are guaranteed one slot per pixel period, issued on the `ce_pix` cycle; host writes are buffered in a small FIFO and drained in the remaining clk cycles. It sits between the video timing/layer logic, the HPS ioctl bus and the framebuffer RAM, so the framebuffer can be rewritten at runtime without tearing the pixel clock schedule.

---
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/vram_arbiter.sv | 137 +++++++++++++
 tb/tb_vram_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: scan-out read port, host write port, RAM port and stall statistic.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface vram_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic          ce_pix;
  logic          vid_rd_en;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   stall_cnt;

  modport slave (
    input  ce_pix, vid_rd_en, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output vid_data, vid_valid, wr_ready, ram_addr, ram_we, ram_wdata, stall_cnt
  );

  modport master (
    output ce_pix, vid_rd_en, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  vid_data, vid_valid, wr_ready, ram_addr, ram_we, ram_wdata, stall_cnt
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter sharing a single-port video RAM between scan-out reads and FIFO-buffered host writes.
// Define VRAM_ARB_STATS_EN to enable the saturating host back-pressure counter on stall_cnt.
module vram_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VIDEO, SLOT_WRITE} slot_e;

  slot_e         slot;
  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [AW-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop, wr_ready;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]    rd_pipe_q, rd_pipe_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;

  // Readiness comes only from registered occupancy: a full FIFO never accepts, even while popping.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign wr_ready = !full && !reset;
  assign push     = bus.wr_valid && wr_ready;
  assign pop      = (slot == SLOT_WRITE);

  always_comb begin
    slot = SLOT_IDLE;
    if (bus.ce_pix && bus.vid_rd_en) begin
      slot = SLOT_VIDEO;
    end else if (!empty) begin
      slot = SLOT_WRITE;
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    if (push) begin
      fifo_addr_d[wr_ptr_q[PW-1:0]] = bus.wr_addr;
      fifo_data_d[wr_ptr_q[PW-1:0]] = bus.wr_data;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
    case (slot)
      SLOT_VIDEO: ram_addr_d = bus.vid_addr;
      SLOT_WRITE: begin
        ram_addr_d  = fifo_addr_q[rd_ptr_q[PW-1:0]];
        ram_wdata_d = fifo_data_q[rd_ptr_q[PW-1:0]];
        ram_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // A video slot mark reaches stage 2 in the cycle the RAM is driving its read data.
  always_comb begin
    rd_pipe_d   = {rd_pipe_q[0], (slot == SLOT_VIDEO)};
    vid_valid_d = rd_pipe_q[1];
    vid_data_d  = rd_pipe_q[1] ? bus.ram_rdata : vid_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rd_pipe_q   <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_valid = vid_valid_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scan-out/host-write scenarios checked every cycle against a
// transaction-level model (write queue + golden memory), plus hand-computed literal expectations.
module tb_vram_arbiter;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM seen by the DUT: read data appears one clk after the address, old data on collision.
  bit [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  // Model: writes are a queue drained into a golden memory, reads return golden contents 3 clks later.
  bit [DW-1:0]   gold [0:(1<<AW)-1];
  wr_t           mq[$];
  wr_t           ent;
  bit            live = 0, pushed = 0, can_push, do_push;
  logic          exp_we = 0, exp_vv = 0, p1_v = 0, p2_v = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_vd = '0, p1_d = '0, p2_d = '0;
  logic [15:0]   exp_stall = '0;

  always @(posedge clk) begin
    if (reset) begin
      live = 1;
      mq.delete();
      exp_we = 0; exp_addr = '0; exp_wdata = '0;
      exp_vv = 0; exp_vd = '0; exp_stall = '0;
      p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0;
      pushed = 0;
    end else begin
      can_push = (mq.size() < DEPTH);
      do_push  = bus.wr_valid && can_push;
`ifdef VRAM_ARB_STATS_EN
      if (bus.wr_valid && !can_push && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
      exp_vv = p2_v;
      if (p2_v) exp_vd = p2_d;
      p2_v = p1_v; p2_d = p1_d; p1_v = 0;
      if (bus.ce_pix && bus.vid_rd_en) begin
        exp_we = 0; exp_addr = bus.vid_addr;
        p1_v = 1; p1_d = gold[bus.vid_addr];
      end else if (mq.size() > 0) begin
        ent = mq.pop_front();
        exp_we = 1; exp_addr = ent.a; exp_wdata = ent.d;
        gold[ent.a] = ent.d;
      end else begin
        exp_we = 0;
      end
      if (do_push) mq.push_back({bus.wr_addr, bus.wr_data});
      pushed = do_push;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      checkOutput("ram_we",    32'(bus.ram_we),    32'(exp_we));
      checkOutput("ram_addr",  32'(bus.ram_addr),  32'(exp_addr));
      checkOutput("ram_wdata", 32'(bus.ram_wdata), 32'(exp_wdata));
      checkOutput("vid_valid", 32'(bus.vid_valid), 32'(exp_vv));
      checkOutput("vid_data",  32'(bus.vid_data),  32'(exp_vd));
      checkOutput("wr_ready",  32'(bus.wr_ready),  32'(!reset && mq.size() < DEPTH));
      checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    end
  end

  task automatic applyStimulus(input logic rd_en, input logic [AW-1:0] vaddr,
                               input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.ce_pix    = (phase == 0);
    bus.vid_rd_en = rd_en;
    bus.vid_addr  = vaddr;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic alignPixel();
    for (int i = 0; i < 4 && phase != 0; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int guard;
    bus.ce_pix = 0; bus.vid_rd_en = 0; bus.vid_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    ram[17'h00010]  = 8'hA5; gold[17'h00010]  = 8'hA5;
    ram[17'h00200]  = 8'h11; gold[17'h00200]  = 8'h11;

    // Reset values and ready release.
    reset = 1;
    idleCycles(3);
    checkOutput("wr_ready_in_reset", 32'(bus.wr_ready), 32'd0);
    reset = 0;
    idleCycles(1);
    checkOutput("reset_wr_ready",  32'(bus.wr_ready),  32'd1);
    checkOutput("reset_ram_we",    32'(bus.ram_we),    32'd0);
    checkOutput("reset_ram_addr",  32'(bus.ram_addr),  32'd0);
    checkOutput("reset_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    checkOutput("reset_vid_valid", 32'(bus.vid_valid), 32'd0);
    checkOutput("reset_vid_data",  32'(bus.vid_data),  32'd0);
    checkOutput("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Single pixel read latency: address at T+1, data strobe only at T+3.
    alignPixel();
    applyStimulus(1'b1, 17'h00010, 1'b0, '0, '0);
    checkOutput("rd_ram_addr_T1", 32'(bus.ram_addr), 32'h10);
    checkOutput("rd_ram_we_T1",   32'(bus.ram_we),   32'd0);
    idleCycles(1);
    checkOutput("rd_valid_T2", 32'(bus.vid_valid), 32'd0);
    idleCycles(1);
    checkOutput("rd_valid_T3", 32'(bus.vid_valid), 32'd1);
    checkOutput("rd_data_T3",  32'(bus.vid_data),  32'hA5);
    idleCycles(1);
    checkOutput("rd_valid_T4", 32'(bus.vid_valid), 32'd0);

    // Burst of 8 host writes during continuous active scan.
    alignPixel();
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 200) begin
      applyStimulus(1'b1, 17'h00010, 1'b1, 17'h00100 + 17'(idx), 8'(idx));
      if (pushed) idx++;
      guard++;
    end
    checkOutput("burst_accept_count", 32'(idx), 32'd8);
    idleCycles(8);
    for (int i = 0; i < 8; i++) checkOutput("burst_ram_content", 32'(ram[17'h00100 + 17'(i)]), 32'(i));

    // Read of a still-queued address returns the old contents; next pixel sees the new value.
    alignPixel();
    applyStimulus(1'b1, 17'h00200, 1'b1, 17'h00200, 8'h3C);
    checkOutput("raw_push_accepted", 32'(pushed), 32'd1);
    idleCycles(2);
    checkOutput("raw_old_valid", 32'(bus.vid_valid), 32'd1);
    checkOutput("raw_old_data",  32'(bus.vid_data),  32'h11);
    alignPixel();
    applyStimulus(1'b1, 17'h00200, 1'b0, '0, '0);
    idleCycles(2);
    checkOutput("raw_new_valid", 32'(bus.vid_valid), 32'd1);
    checkOutput("raw_new_data",  32'(bus.vid_data),  32'h3C);
    idleCycles(4);

    // Build up three queued entries during active scan, then reset: they must never be written.
    alignPixel();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 17'h00010, 1'b1, 17'h00400 + 17'(i), 8'h80 + 8'(i));
      checkOutput("preq_push", 32'(pushed), 32'd1);
    end
    reset = 1;
    idleCycles(2);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      idleCycles(1);
      checkOutput("post_reset_ram_we", 32'(bus.ram_we), 32'd0);
    end
    checkOutput("post_reset_written", 32'(ram[17'h00405]), 32'h85);
    for (int i = 6; i < 9; i++) checkOutput("post_reset_untouched", 32'(ram[17'h00400 + 17'(i)]), 32'd0);

    // Continuous writes against active scan: FIFO fills at cycle 13, then one stall per pixel.
    alignPixel();
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      applyStimulus(1'b1, 17'h00010, 1'b1, 17'h00500 + 17'(idx), 8'(idx));
      if (pushed) idx++;
      if (c == 11) checkOutput("fill_ready_c12", 32'(bus.wr_ready), 32'd1);
      if (c == 12) checkOutput("fill_ready_c13", 32'(bus.wr_ready), 32'd0);
    end
`ifdef VRAM_ARB_STATS_EN
    checkOutput("stall_cnt_final", 32'(bus.stall_cnt), 32'd10);
`else
    checkOutput("stall_cnt_final", 32'(bus.stall_cnt), 32'd0);
`endif
    idleCycles(10);
    checkOutput("stream_last_write", 32'(ram[17'h00500 + 17'(idx - 1)]), 32'(8'(idx - 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
